// File: rtl/drone_ctrl_pkg.sv
// Shared constants for the drone on/off control path: gesture codes,
// controller state encoding and on/off values used by the state register.
package drone_ctrl_pkg;

    localparam int unsigned GEST_W  = 3;
    localparam int unsigned STATE_W = 3;

    // Gesture classifier output codes; 3..7 are movement commands
    localparam logic [GEST_W-1:0] GEST_NONE     = 3'd0;
    localparam logic [GEST_W-1:0] GEST_ON       = 3'd1;
    localparam logic [GEST_W-1:0] GEST_OFF      = 3'd2;
    localparam logic [GEST_W-1:0] GEST_MOVE_MIN = 3'd3;

    // Controller state encoding, also exported on ctrl_state
    localparam logic [STATE_W-1:0] S_OFF       = 3'd0;
    localparam logic [STATE_W-1:0] S_ARMING    = 3'd1;
    localparam logic [STATE_W-1:0] S_ON        = 3'd2;
    localparam logic [STATE_W-1:0] S_DISARMING = 3'd3;
    localparam logic [STATE_W-1:0] S_HOLDOFF   = 3'd4;

    // Drone on/off register values
    localparam logic OFF = 1'b0;
    localparam logic ON  = 1'b1;

endpackage

// File: rtl/gesture_arm_controller_if.sv
// Classifier-to-controller bus: gesture frames and on/off feedback in,
// command pulses and debug state out.
interface gesture_arm_controller_if;
    import drone_ctrl_pkg::*;

    logic               gesture_valid;
    logic [GEST_W-1:0]  gesture_code;
    logic               on_off_s;
    logic               is_on;
    logic               is_off;
    logic               auto_off;
    logic [STATE_W-1:0] ctrl_state;

    // Environment side: classifier plus on/off state register
    modport master (
        output gesture_valid,
        output gesture_code,
        output on_off_s,
        input  is_on,
        input  is_off,
        input  auto_off,
        input  ctrl_state
    );

    // Controller side
    modport slave (
        input  gesture_valid,
        input  gesture_code,
        input  on_off_s,
        output is_on,
        output is_off,
        output auto_off,
        output ctrl_state
    );

endinterface

// File: rtl/activity_watchdog.sv
// Clearable, enable-gated saturating cycle counter; expired_c is high for the
// single enabled cycle in which the count sits at LIMIT-1.
module activity_watchdog #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over counting; count parks at LIMIT so expiry cannot repeat
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = enable_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/gesture_arm_controller.sv
// Turns the classified gesture stream into confirmed is_on/is_off commands,
// with post-command hold-off, inactivity auto-off and on/off feedback resync.
module gesture_arm_controller
    import drone_ctrl_pkg::*;
#(
    parameter int unsigned CONFIRM_FRAMES  = 8,
    parameter int unsigned COOLDOWN_CYCLES = 27000000,
    parameter int unsigned TIMEOUT_CYCLES  = 81000000
) (
    input  logic                     clock,
    input  logic                     reset,
    gesture_arm_controller_if.slave  bus
);

    localparam int unsigned FW = $clog2(CONFIRM_FRAMES + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    logic               is_on_q, is_on_d;
    logic               is_off_q, is_off_d;
    logic               auto_off_q, auto_off_d;

    logic          gest_on_c;
    logic          gest_off_c;
    logic          activity_c;
    logic          wd_active_c;
    logic          wd_clear_c;
    logic          timeout_c;
    logic          cd_active_c;
    logic          cooldown_done_c;
    logic [FW-1:0] frame_inc_c;
    logic          confirm_c;

    assign gest_on_c   = bus.gesture_valid && (bus.gesture_code == GEST_ON);
    assign gest_off_c  = bus.gesture_valid && (bus.gesture_code == GEST_OFF);
    assign activity_c  = bus.gesture_valid && (bus.gesture_code != GEST_NONE);
    assign wd_active_c = (state_q == S_ON) || (state_q == S_DISARMING);
    assign cd_active_c = (state_q == S_HOLDOFF);

    // Saturating frame increment; reaching CONFIRM_FRAMES is the confirm
    assign frame_inc_c = (frame_cnt_q == FW'(CONFIRM_FRAMES)) ? frame_cnt_q
                                                              : frame_cnt_q + FW'(1);
    assign confirm_c   = (frame_inc_c == FW'(CONFIRM_FRAMES));

    // Watchdog restarts on activity, whenever idle, and on every entry to S_ON
    assign wd_clear_c = !wd_active_c || activity_c ||
                        ((state_d == S_ON) && (state_q != S_ON));

    activity_watchdog #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (wd_clear_c),
        .enable_i  (wd_active_c),
        .expired_c (timeout_c)
    );

    activity_watchdog #(
        .LIMIT     (COOLDOWN_CYCLES)
    ) u_cooldown (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (!cd_active_c),
        .enable_i  (cd_active_c),
        .expired_c (cooldown_done_c)
    );

    // Next-state and command decode; feedback resync outranks gestures and timeout
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        is_on_d     = 1'b0;
        is_off_d    = 1'b0;
        auto_off_d  = 1'b0;

        case (state_q)
            S_OFF: begin
                if (bus.on_off_s == ON) begin
                    state_d     = S_ON;
                    frame_cnt_d = '0;
                end else if (gest_on_c) begin
                    state_d     = S_ARMING;
                    frame_cnt_d = FW'(1);
                end
            end

            S_ARMING: begin
                if (bus.on_off_s == ON) begin
                    state_d     = S_ON;
                    frame_cnt_d = '0;
                end else if (gest_on_c) begin
                    if (confirm_c) begin
                        is_on_d     = 1'b1;
                        state_d     = S_HOLDOFF;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_inc_c;
                    end
                end else if (bus.gesture_valid) begin
                    state_d     = S_OFF;
                    frame_cnt_d = '0;
                end
            end

            S_ON: begin
                if (bus.on_off_s == OFF) begin
                    state_d     = S_OFF;
                    frame_cnt_d = '0;
                end else if (timeout_c) begin
                    is_off_d    = 1'b1;
                    auto_off_d  = 1'b1;
                    state_d     = S_HOLDOFF;
                    frame_cnt_d = '0;
                end else if (gest_off_c) begin
                    state_d     = S_DISARMING;
                    frame_cnt_d = FW'(1);
                end
            end

            S_DISARMING: begin
                if (bus.on_off_s == OFF) begin
                    state_d     = S_OFF;
                    frame_cnt_d = '0;
                end else if (timeout_c || (gest_off_c && confirm_c)) begin
                    // A coincident timeout and confirm still yield one is_off
                    is_off_d    = 1'b1;
                    auto_off_d  = timeout_c;
                    state_d     = S_HOLDOFF;
                    frame_cnt_d = '0;
                end else if (gest_off_c) begin
                    frame_cnt_d = frame_inc_c;
                end else if (bus.gesture_valid) begin
                    state_d     = S_ON;
                    frame_cnt_d = '0;
                end
            end

            S_HOLDOFF: begin
                if (cooldown_done_c) begin
                    state_d     = (bus.on_off_s == ON) ? S_ON : S_OFF;
                    frame_cnt_d = '0;
                end
            end

            default: begin
                state_d     = S_OFF;
                frame_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_OFF;
            frame_cnt_q <= '0;
            is_on_q     <= 1'b0;
            is_off_q    <= 1'b0;
            auto_off_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            is_on_q     <= is_on_d;
            is_off_q    <= is_off_d;
            auto_off_q  <= auto_off_d;
        end
    end

    assign bus.is_on      = is_on_q;
    assign bus.is_off     = is_off_q;
    assign bus.auto_off   = auto_off_q;
    assign bus.ctrl_state = state_q;

endmodule

// File: tb/tb_gesture_arm_controller.sv
// Directed bench for gesture_arm_controller with an on/off state register
// model closing the feedback loop.
module tb_gesture_arm_controller;

    localparam logic [2:0] ST_OFF  = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_ON   = 3'd2;
    localparam logic [2:0] ST_DIS  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    localparam logic [2:0] G_NONE = 3'd0;
    localparam logic [2:0] G_ON   = 3'd1;
    localparam logic [2:0] G_OFF  = 3'd2;
    localparam logic [2:0] G_MOVE = 3'd5;

    logic clock = 1'b0;
    logic reset;
    logic model_q;
    logic force_en;
    logic force_val;

    int checks = 0;
    int errors = 0;
    int n_on   = 0;
    int n_off  = 0;
    int n_auto = 0;
    int n_both = 0;

    always #5 clock = ~clock;

    gesture_arm_controller_if bus ();

    gesture_arm_controller #(
        .CONFIRM_FRAMES  (4),
        .COOLDOWN_CYCLES (16),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // On/off state register model, optionally overridden to emulate external changes
    always @(posedge clock) begin
        if (reset)            model_q <= 1'b0;
        else if (bus.is_on)   model_q <= 1'b1;
        else if (bus.is_off)  model_q <= 1'b0;
    end

    assign bus.on_off_s = force_en ? force_val : model_q;

    always @(posedge clock) begin
        if (bus.is_on)                n_on   <= n_on + 1;
        if (bus.is_off)               n_off  <= n_off + 1;
        if (bus.auto_off)             n_auto <= n_auto + 1;
        if (bus.is_on && bus.is_off)  n_both <= n_both + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] code);
        bus.gesture_valid = 1'b1;
        bus.gesture_code  = code;
        tick(1);
        bus.gesture_valid = 1'b0;
        bus.gesture_code  = G_NONE;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.gesture_valid = 1'b0;
        bus.gesture_code  = G_NONE;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic arm();
        do_reset();
        repeat (4) send(G_ON);
        tick(16);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.ctrl_state !== ST_OFF) begin
            errors++; $display("FAIL reset_state: got %0d expected %0d", bus.ctrl_state, ST_OFF);
        end
        checks++;
        if ({bus.is_on, bus.is_off, bus.auto_off} !== 3'b000) begin
            errors++; $display("FAIL reset_outputs: got %b expected 000", {bus.is_on, bus.is_off, bus.auto_off});
        end
        reset = 1'b0;
    endtask

    task automatic test_arm();
        int base_on;
        do_reset();
        base_on = n_on;
        send(G_ON);
        checks++;
        if (bus.ctrl_state !== ST_ARM) begin
            errors++; $display("FAIL arm_first: got %0d expected %0d", bus.ctrl_state, ST_ARM);
        end
        tick(2); send(G_ON);
        tick(2); send(G_ON);
        tick(2); send(G_ON);
        checks++;
        if (bus.is_on !== 1'b1 || bus.is_off !== 1'b0) begin
            errors++; $display("FAIL arm_pulse: got on=%b off=%b expected on=1 off=0", bus.is_on, bus.is_off);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.ctrl_state !== ST_HOLD) begin
                errors++; $display("FAIL arm_holdoff[%0d]: got %0d expected %0d", i, bus.ctrl_state, ST_HOLD);
            end
            tick(1);
        end
        checks++;
        if (bus.ctrl_state !== ST_ON) begin
            errors++; $display("FAIL arm_on: got %0d expected %0d", bus.ctrl_state, ST_ON);
        end
        checks++;
        if (bus.on_off_s !== 1'b1) begin
            errors++; $display("FAIL arm_feedback: got %b expected 1", bus.on_off_s);
        end
        checks++;
        if (n_on - base_on !== 1) begin
            errors++; $display("FAIL arm_pulse_count: got %0d expected 1", n_on - base_on);
        end
    endtask

    task automatic test_broken_arm();
        int base_on;
        do_reset();
        base_on = n_on;
        send(G_ON); send(G_ON); send(G_ON);
        send(G_NONE);
        checks++;
        if (bus.ctrl_state !== ST_OFF) begin
            errors++; $display("FAIL broken_after_none: got %0d expected %0d", bus.ctrl_state, ST_OFF);
        end
        send(G_ON);
        checks++;
        if (bus.ctrl_state !== ST_ARM) begin
            errors++; $display("FAIL broken_rearm: got %0d expected %0d", bus.ctrl_state, ST_ARM);
        end
        tick(3);
        checks++;
        if (n_on - base_on !== 0) begin
            errors++; $display("FAIL broken_no_pulse: got %0d expected 0", n_on - base_on);
        end
    endtask

    task automatic test_disarm_cooldown();
        int base_on;
        int base_off;
        int base_auto;
        arm();
        base_on = n_on; base_off = n_off; base_auto = n_auto;
        send(G_OFF);
        checks++;
        if (bus.ctrl_state !== ST_DIS) begin
            errors++; $display("FAIL disarm_enter: got %0d expected %0d", bus.ctrl_state, ST_DIS);
        end
        send(G_OFF); send(G_OFF); send(G_OFF);
        checks++;
        if (bus.is_off !== 1'b1 || bus.auto_off !== 1'b0 || bus.is_on !== 1'b0) begin
            errors++; $display("FAIL disarm_pulse: got on=%b off=%b auto=%b expected 0 1 0",
                               bus.is_on, bus.is_off, bus.auto_off);
        end
        repeat (7) begin
            send(G_ON);
            tick(1);
        end
        tick(4);
        checks++;
        if (bus.ctrl_state !== ST_OFF) begin
            errors++; $display("FAIL disarm_after_hold: got %0d expected %0d", bus.ctrl_state, ST_OFF);
        end
        checks++;
        if (n_on - base_on !== 0 || n_off - base_off !== 1 || n_auto - base_auto !== 0) begin
            errors++; $display("FAIL disarm_counts: got on=%0d off=%0d auto=%0d expected 0 1 0",
                               n_on - base_on, n_off - base_off, n_auto - base_auto);
        end
    endtask

    task automatic test_timeout();
        int base_off;
        int base_auto;
        arm();
        base_off = n_off; base_auto = n_auto;
        for (int i = 0; i < 100; i++) send(G_NONE);
        checks++;
        if (bus.is_off !== 1'b1 || bus.auto_off !== 1'b1) begin
            errors++; $display("FAIL timeout_pulse: got off=%b auto=%b expected 1 1", bus.is_off, bus.auto_off);
        end
        checks++;
        if (n_off - base_off !== 0) begin
            errors++; $display("FAIL timeout_early: got %0d earlier is_off pulses expected 0", n_off - base_off);
        end
        tick(1);
        checks++;
        if (bus.on_off_s !== 1'b0 || bus.ctrl_state !== ST_HOLD) begin
            errors++; $display("FAIL timeout_after: got on_off_s=%b state=%0d expected 0 4",
                               bus.on_off_s, bus.ctrl_state);
        end
        checks++;
        if (n_auto - base_auto !== 1) begin
            errors++; $display("FAIL timeout_auto_count: got %0d expected 1", n_auto - base_auto);
        end

        arm();
        base_off = n_off;
        repeat (6) begin
            send(G_MOVE);
            tick(49);
        end
        checks++;
        if (n_off - base_off !== 0 || bus.ctrl_state !== ST_ON) begin
            errors++; $display("FAIL timeout_kept_alive: got off=%0d state=%0d expected 0 2",
                               n_off - base_off, bus.ctrl_state);
        end
    endtask

    task automatic test_feedback_resync();
        int base_on;
        int base_off;
        arm();
        send(G_OFF); send(G_OFF);
        checks++;
        if (bus.ctrl_state !== ST_DIS) begin
            errors++; $display("FAIL resync_pre: got %0d expected %0d", bus.ctrl_state, ST_DIS);
        end
        base_on = n_on; base_off = n_off;
        force_val = 1'b0;
        force_en  = 1'b1;
        tick(1);
        checks++;
        if (bus.ctrl_state !== ST_OFF) begin
            errors++; $display("FAIL resync_off: got %0d expected %0d", bus.ctrl_state, ST_OFF);
        end
        force_en = 1'b0;
        tick(1);
        checks++;
        if (bus.ctrl_state !== ST_ON) begin
            errors++; $display("FAIL resync_on: got %0d expected %0d", bus.ctrl_state, ST_ON);
        end
        tick(1);
        checks++;
        if (n_on - base_on !== 0 || n_off - base_off !== 0) begin
            errors++; $display("FAIL resync_no_pulse: got on=%0d off=%0d expected 0 0",
                               n_on - base_on, n_off - base_off);
        end
    endtask

    task automatic test_reset_mid_sequence();
        int base_on;
        do_reset();
        base_on = n_on;
        send(G_ON); send(G_ON); send(G_ON);
        reset = 1'b1;
        tick(1);
        checks++;
        if (bus.ctrl_state !== ST_OFF) begin
            errors++; $display("FAIL midreset_state: got %0d expected %0d", bus.ctrl_state, ST_OFF);
        end
        reset = 1'b0;
        send(G_ON);
        checks++;
        if (bus.ctrl_state !== ST_ARM || bus.is_on !== 1'b0) begin
            errors++; $display("FAIL midreset_one_frame: got state=%0d on=%b expected 1 0",
                               bus.ctrl_state, bus.is_on);
        end
        send(G_ON); send(G_ON);
        checks++;
        if (bus.ctrl_state !== ST_ARM || n_on - base_on !== 0) begin
            errors++; $display("FAIL midreset_three_frames: got state=%0d pulses=%0d expected 1 0",
                               bus.ctrl_state, n_on - base_on);
        end
        send(G_ON);
        checks++;
        if (bus.is_on !== 1'b1) begin
            errors++; $display("FAIL midreset_confirm: got %b expected 1", bus.is_on);
        end
    endtask

    initial begin
        reset = 1'b1;
        force_en = 1'b0;
        force_val = 1'b0;
        bus.gesture_valid = 1'b0;
        bus.gesture_code = G_NONE;
        tick(2);
        test_reset();
        test_arm();
        test_broken_arm();
        test_disarm_cooldown();
        test_timeout();
        test_feedback_resync();
        test_reset_mid_sequence();
        tick(2);
        checks++;
        if (n_both !== 0) begin
            errors++; $display("FAIL exclusive_pulses: got %0d overlaps expected 0", n_both);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish within bound expected finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
